// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes, coin values and dispenser state encoding.
// The inventory feature of change_dispenser is enabled with CHANGE_INVENTORY_EN.
package vending_pkg;

  localparam int COIN_VAL_W = 16;

  localparam logic [1:0] COIN_500  = 2'b00;
  localparam logic [1:0] COIN_1000 = 2'b01;
  localparam logic [1:0] COIN_2000 = 2'b10;
  localparam logic [1:0] COIN_5000 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    DONE,
    ERROR
  } state_e;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    logic [COIN_VAL_W-1:0] v;
    case (code)
      COIN_500:  v = 16'd500;
      COIN_1000: v = 16'd1000;
      COIN_2000: v = 16'd2000;
      default:   v = 16'd5000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin pick: largest available denomination whose value fits in the remaining amount.
module coin_selector
  import vending_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic [AMT_W-1:0] remaining_i,
  input  logic [3:0]       avail_i,
  output logic             found_o,
  output logic [1:0]       code_o
);

  logic [31:0] rem_wide;
  assign rem_wide = 32'(remaining_i);

  // Ascending scan so that a larger fitting coin overrides a smaller one.
  always_comb begin
    found_o = 1'b0;
    code_o  = COIN_500;
    for (int i = 0; i < 4; i++) begin
      if (avail_i[i] && (32'(coin_value(2'(i))) <= rem_wide)) begin
        found_o = 1'b1;
        code_o  = 2'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: accepts an amount, offers coins to the hopper largest first, reports done/error.
// Define CHANGE_INVENTORY_EN to track per-denomination coin counts with refill.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W      = 16,
  parameter int CNT_W      = 8,
  parameter int INIT_COINS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic             coin_valid,
  output logic [1:0]       coin_code,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] residual,
  input  logic             refill,
  input  logic [1:0]       refill_code
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] residual_q, residual_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       avail;
  logic             sel_found;
  logic [1:0]       sel_code;
  logic             coin_taken;
  logic [AMT_W-1:0] coin_amt;

  assign coin_taken = (state_q == ISSUE) && coin_ack;
  assign coin_amt   = AMT_W'(coin_value(code_q));

`ifdef CHANGE_INVENTORY_EN
  logic [CNT_W-1:0] count_q [4];
  logic [CNT_W-1:0] count_d [4];
  logic [3:0]       inc_req, dec_req;

  // Simultaneous refill and payout of the same denomination cancel out.
  always_comb begin
    inc_req = '0;
    dec_req = '0;
    for (int i = 0; i < 4; i++) begin
      count_d[i] = count_q[i];
      inc_req[i] = refill && (refill_code == 2'(i));
      dec_req[i] = coin_taken && (code_q == 2'(i));
      if (inc_req[i] && !dec_req[i]) begin
        if (count_q[i] != '1) count_d[i] = count_q[i] + 1'b1;
      end else if (dec_req[i] && !inc_req[i]) begin
        if (count_q[i] != '0) count_d[i] = count_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) count_q[i] <= CNT_W'(INIT_COINS);
    end else begin
      for (int i = 0; i < 4; i++) count_q[i] <= count_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) avail[i] = (count_q[i] != '0);
  end
`else
  logic unused_refill;
  assign unused_refill = ^{refill, refill_code, CNT_W[0], INIT_COINS[0]};
  assign avail         = 4'hF;
`endif

  coin_selector #(.AMT_W(AMT_W)) u_sel (
    .remaining_i (remaining_q),
    .avail_i     (avail),
    .found_o     (sel_found),
    .code_o      (sel_code)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    residual_d  = residual_q;
    code_d      = code_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          residual_d  = '0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          code_d  = sel_code;
          state_d = ISSUE;
        end else if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = ERROR;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_amt;
          state_d     = SELECT;
        end
      end
      DONE:  state_d = IDLE;
      ERROR: begin
        residual_d = remaining_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      residual_q  <= '0;
      code_q      <= COIN_500;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residual_q  <= residual_d;
      code_q      <= code_d;
    end
  end

  // Outputs decode the state register so reset removes the coin offer immediately.
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign coin_valid = (state_q == ISSUE);
  assign coin_code  = code_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign residual   = residual_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table plus reset, hold and inventory sequences.
module tb_change_dispenser;

  localparam int AMT_W = 16;
`ifdef CHANGE_INVENTORY_EN
  localparam int CNT_W      = 2;
  localparam int INIT_COINS = 1;
`else
  localparam int CNT_W      = 8;
  localparam int INIT_COINS = 10;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount = '0;
  logic             coin_valid;
  logic [1:0]       coin_code;
  logic             coin_ack = 1'b0;
  logic             busy, done, error;
  logic [AMT_W-1:0] residual;
  logic             refill = 1'b0;
  logic [1:0]       refill_code = 2'b00;

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_COINS(INIT_COINS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_ack(coin_ack), .busy(busy), .done(done), .error(error), .residual(residual),
    .refill(refill), .refill_code(refill_code)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [1:0] got[$];
  bit         got_done, got_err, hold_ok, timed_out;
  int         first_k;

  // noise: pulse req_valid while a coin is offered and coin_ack while none is offered.
  task automatic run_req(input logic [15:0] amt, input int dly, input bit noise,
                         input bit refill_ack, input logic [1:0] rcode);
    bit         in_offer;
    int         held;
    logic [1:0] cur;
    got.delete();
    got_done = 0; got_err = 0; hold_ok = 1; timed_out = 1; first_k = -1;
    in_offer = 0; held = 0; cur = 2'b00;
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 1);
    req_valid = 1'b1; req_amount = amt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      req_valid = 1'b0; coin_ack = 1'b0; refill = 1'b0;
      if (coin_valid) begin
        if (first_k < 0) first_k = k;
        if (!in_offer) begin
          in_offer = 1; held = 0; cur = coin_code; got.push_back(coin_code);
        end else if (coin_code !== cur) begin
          hold_ok = 0;
        end
        if (noise) begin req_valid = 1'b1; req_amount = 16'd500; end
        if (held == dly) begin
          coin_ack = 1'b1;
          if (refill_ack) begin refill = 1'b1; refill_code = rcode; end
        end
        held++;
      end else begin
        in_offer = 0;
        if (noise) coin_ack = 1'b1;
      end
      if (done || error) begin
        if (first_k < 0) first_k = k;
        got_done = done; got_err = error; timed_out = 0;
        break;
      end
    end
    req_valid = 1'b0; coin_ack = 1'b0; refill = 1'b0;
    if (timed_out) chk("transaction_timeout", 1, 0);
  endtask

  // codes: coin i of the expected sequence sits in bits [2i+1:2i].
  task automatic expect_txn(input string nm, input logic [31:0] codes, input int n,
                            input bit err, input logic [15:0] res);
    chk({nm, " coin_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s coin%0d", nm, i), 32'(got[i]), 32'((codes >> (2 * i)) & 32'h3));
    chk({nm, " latency"}, 32'(first_k), 2);
    chk({nm, " code_held"}, 32'(hold_ok), 1);
    chk({nm, " done"}, 32'(got_done), 32'(!err));
    chk({nm, " error"}, 32'(got_err), 32'(err));
    @(negedge clk);
    chk({nm, " residual"}, 32'(residual), 32'(res));
    chk({nm, " ready_after"}, 32'(req_ready), 1);
    chk({nm, " busy_after"}, 32'(busy), 0);
  endtask

  task automatic refill_pulse(input logic [1:0] code);
    @(negedge clk);
    refill = 1'b1; refill_code = code;
    @(negedge clk);
    refill = 1'b0;
  endtask

  typedef struct {
    logic [15:0] amt;
    int          dly;
    bit          noise;
    logic [31:0] codes;
    int          n;
    bit          err;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #3;
    chk("rst coin_valid", 32'(coin_valid), 0);
    chk("rst coin_code", 32'(coin_code), 0);
    chk("rst done", 32'(done), 0);
    chk("rst error", 32'(error), 0);
    chk("rst residual", 32'(residual), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst req_ready", 32'(req_ready), 1);
    @(negedge clk);
    reset = 1'b1;

`ifdef CHANGE_INVENTORY_EN
    run_req(16'd10000, 1, 0, 0, 2'b00);
    expect_txn("inv_10000", 32'h1B, 4, 1, 16'd1500);
    run_req(16'd500, 1, 0, 0, 2'b00);
    expect_txn("inv_empty_500", 32'h0, 0, 1, 16'd500);
    refill_pulse(2'b00);
    run_req(16'd500, 1, 0, 0, 2'b00);
    expect_txn("inv_refilled_500", 32'h0, 1, 0, 16'd0);
    refill_pulse(2'b11);
    run_req(16'd5000, 1, 0, 1, 2'b11);
    expect_txn("inv_ack_refill", 32'h3, 1, 0, 16'd0);
    run_req(16'd5000, 1, 0, 0, 2'b00);
    expect_txn("inv_count_kept", 32'h3, 1, 0, 16'd0);
    run_req(16'd5000, 1, 0, 0, 2'b00);
    expect_txn("inv_count_gone", 32'h0, 0, 1, 16'd5000);
    for (int i = 0; i < 5; i++) refill_pulse(2'b01);
    run_req(16'd4000, 0, 0, 0, 2'b00);
    expect_txn("inv_saturate", 32'h15, 3, 1, 16'd1000);
`else
    vecs[0] = '{amt: 16'd8500,  dly: 1, noise: 0, codes: 32'h1B,       n: 4,  err: 0, res: 16'd0};
    vecs[1] = '{amt: 16'd0,     dly: 1, noise: 0, codes: 32'h0,        n: 0,  err: 0, res: 16'd0};
    vecs[2] = '{amt: 16'd700,   dly: 1, noise: 0, codes: 32'h0,        n: 1,  err: 1, res: 16'd200};
    vecs[3] = '{amt: 16'd3000,  dly: 3, noise: 1, codes: 32'h6,        n: 2,  err: 0, res: 16'd0};
    vecs[4] = '{amt: 16'd10000, dly: 0, noise: 0, codes: 32'hF,        n: 2,  err: 0, res: 16'd0};
    vecs[5] = '{amt: 16'd65535, dly: 0, noise: 0, codes: 32'h03FFFFFF, n: 14, err: 1, res: 16'd35};
    vecs[6] = '{amt: 16'd499,   dly: 2, noise: 0, codes: 32'h0,        n: 0,  err: 1, res: 16'd499};
    vecs[7] = '{amt: 16'd4500,  dly: 0, noise: 0, codes: 32'hA,        n: 3,  err: 0, res: 16'd0};
    for (int v = 0; v < 8; v++) begin
      run_req(vecs[v].amt, vecs[v].dly, vecs[v].noise, 0, 2'b00);
      expect_txn($sformatf("vec%0d_%0d", v, vecs[v].amt), vecs[v].codes, vecs[v].n,
                 vecs[v].err, vecs[v].res);
    end

    // Extra cycles after the noisy request must stay idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_idle%0d", i), 32'({coin_valid, busy}), 0);
    end

    // Reset in the middle of the second coin of 8500.
    @(negedge clk);
    req_valid = 1'b1; req_amount = 16'd8500;
    @(posedge clk);
    #1 req_valid = 1'b0;
    begin
      int  ncoin;
      bit  prev;
      bit  reached;
      ncoin = 0; prev = 0; reached = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        coin_ack = 1'b0;
        if (coin_valid && !prev) ncoin++;
        prev = coin_valid;
        if (ncoin == 2) begin reached = 1; break; end
        if (coin_valid) coin_ack = 1'b1;
      end
      chk("rst_mid second_coin_seen", 32'(reached), 1);
    end
    chk("rst_mid second_code", 32'(coin_code), 2);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid coin_valid", 32'(coin_valid), 0);
    chk("rst_mid busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rel req_ready", 32'(req_ready), 1);
    chk("rst_rel residual", 32'(residual), 0);
    chk("rst_rel coin_valid", 32'(coin_valid), 0);

    // Reset while idle clears a residual left by an error.
    run_req(16'd700, 1, 0, 0, 2'b00);
    expect_txn("pre_rst_700", 32'h0, 1, 1, 16'd200);
    reset = 1'b0;
    #1 chk("rst_idle residual", 32'(residual), 0);
    @(negedge clk);
    reset = 1'b1;
    run_req(16'd1500, 1, 0, 0, 2'b00);
    expect_txn("after_rst_1500", 32'h1, 2, 0, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
